// File: rtl/to_proj_rz.sv
// Affine Edwards (x, y) mod P -> extended projective (X, Y, Z, T), with optional
// randomised-Z blinding, built around one shared bit-serial modular multiplier.
module to_proj_rz #(
  parameter int            N = 255,
  parameter logic [N-1:0]  P = {N{1'b1}} - N'(18)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [N-1:0] Px,
  input  logic [N-1:0] Py,
  input  logic [N-1:0] Zin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         err,
  output logic [N-1:0] Rx,
  output logic [N-1:0] Ry,
  output logic [N-1:0] Rz,
  output logic [N-1:0] Rt,
  output logic [1:0]   dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // sender holds its data stable until then, and ready never depends on valid.

  typedef enum logic [1:0] {IDLE, MSETUP, MRUN, DONE} state_t;

  localparam int CW = $clog2(N);

  state_t        state, state_nx;
  logic [N+1:0]  acc;
  logic [N-1:0]  a_op, b_sh;
  logic [CW-1:0] bitcnt;
  logic [1:0]    step;
  logic          mr;
  logic [N-1:0]  xr, yr, zr, tr;

  logic [N-1:0]  sel_a, sel_b;
  logic [N+1:0]  sum, red1, red2;
  logic [N-1:0]  prod;
  logic          bad, last_bit, last_step;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign dbg_state = state;

  assign bad       = (Px >= P) || (Py >= P) || (mode && ((Zin == '0) || (Zin >= P)));
  assign last_bit  = (bitcnt == '0);
  assign last_step = mr ? (step == 2'd3) : (step == 2'd0);

  // 2*acc + a < 3P fits in N+2 bits; two conditional subtractions bring it below P.
  assign sum  = (acc << 1) + {2'b00, (b_sh[N-1] ? a_op : '0)};
  assign red1 = (sum  >= {2'b00, P}) ? sum  - {2'b00, P} : sum;
  assign red2 = (red1 >= {2'b00, P}) ? red1 - {2'b00, P} : red1;
  assign prod = red2[N-1:0];

  // Step operands: T1=x*y, X=x*Z, Y=y*Z, T=T1*Z; results overwrite spent inputs.
  always_comb begin
    sel_a = xr;
    sel_b = yr;
    case (step)
      2'd0: begin sel_a = xr; sel_b = yr; end
      2'd1: begin sel_a = xr; sel_b = zr; end
      2'd2: begin sel_a = yr; sel_b = zr; end
      2'd3: begin sel_a = tr; sel_b = zr; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = bad ? DONE : MSETUP;
      MSETUP:  state_nx = MRUN;
      MRUN:    if (last_bit) state_nx = last_step ? DONE : MSETUP;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      a_op   <= '0;
      b_sh   <= '0;
      bitcnt <= '0;
      step   <= '0;
      mr     <= 1'b0;
      xr     <= '0;
      yr     <= '0;
      zr     <= '0;
      tr     <= '0;
      err    <= 1'b0;
      Rx     <= '0;
      Ry     <= '0;
      Rz     <= '0;
      Rt     <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          xr   <= Px;
          yr   <= Py;
          zr   <= Zin;
          mr   <= mode;
          step <= 2'd0;
          if (bad) begin
            err <= 1'b1;
            Rx  <= '0;
            Ry  <= '0;
            Rz  <= '0;
            Rt  <= '0;
          end
        end
        MSETUP: begin
          acc    <= '0;
          a_op   <= sel_a;
          b_sh   <= sel_b;
          bitcnt <= CW'(N - 1);
        end
        MRUN: begin
          acc    <= red2;
          b_sh   <= b_sh << 1;
          bitcnt <= bitcnt - 1'b1;
          if (last_bit) begin
            case (step)
              2'd1:    xr <= prod;
              2'd2:    yr <= prod;
              default: tr <= prod;
            endcase
            if (last_step) begin
              err <= 1'b0;
              Rx  <= xr;
              Ry  <= yr;
              Rz  <= mr ? zr : {{(N-1){1'b0}}, 1'b1};
              Rt  <= prod;
            end else begin
              step <= step + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
